// File: rtl/mux_pkg.sv
// Shared select encoding for the registered 4:1 multiplexer.
// The select code is {sel1, sel2}, with sel1 as the MSB.
package mux_pkg;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_A = 2'b00;
   localparam sel_t SEL_B = 2'b01;
   localparam sel_t SEL_C = 2'b10;
   localparam sel_t SEL_D = 2'b11;

endpackage : mux_pkg

// File: rtl/mux4to1_comb.sv
// Purely combinational WIDTH-bit 4:1 selector.
// Every bit is routed by the same 2-bit select code.
module mux4to1_comb
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_c,
   input  logic [WIDTH-1:0] i_d,
   input  logic [1:0]       i_sel,
   output logic [WIDTH-1:0] o_y
);

   // Select one data word; an unknown select code yields X in simulation
   // and is a don't-care for synthesis.
   always_comb begin
      o_y = {WIDTH{1'b0}};
      case (i_sel)
         SEL_A:   o_y = i_a;
         SEL_B:   o_y = i_b;
         SEL_C:   o_y = i_c;
         SEL_D:   o_y = i_d;
         default: o_y = {WIDTH{1'bx}};
      endcase
   end

endmodule : mux4to1_comb

// File: rtl/mux4to1_reg.sv
// Registered 4:1 multiplexer: y shows the selection sampled at the previous
// rising clk edge, and clears asynchronously while rst_n is low.
module mux4to1_reg
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic             sel1,
   input  logic             sel2,
   output logic [WIDTH-1:0] y
);

   sel_t             w_sel;
   logic [WIDTH-1:0] w_mux;
   logic [WIDTH-1:0] r_y;

   assign w_sel = {sel1, sel2};

   mux4to1_comb #(
      .WIDTH (WIDTH)
   ) u_comb (
      .i_a   (a),
      .i_b   (b),
      .i_c   (c),
      .i_d   (d),
      .i_sel (w_sel),
      .o_y   (w_mux)
   );

   // Output register: loads every cycle, cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y <= {WIDTH{1'b0}};
      end else begin
         r_y <= w_mux;
      end
   end

   assign y = r_y;

endmodule : mux4to1_reg

// File: tb/tb_mux4to1_reg.sv
// Scoreboard bench for mux4to1_reg (WIDTH=8): the driver queues the
// hand-computed value expected one edge later, the monitor pops and compares.
module tb_mux4to1_reg;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] a, b, c, d;
   logic         sel1, sel2;
   logic [W-1:0] y;

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           n_cmp;
   int           n_bad;

   mux4to1_reg #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d),
      .sel1  (sel1),
      .sel2  (sel2),
      .y     (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_now(input string nm, input logic [W-1:0] exp_v);
      n_cmp = n_cmp + 1;
      if (y !== exp_v) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: y=%h expected=%h", nm, y, exp_v);
      end
   endtask

   // Drive one vector at the falling edge and queue its expected result.
   task automatic apply(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] vc, input logic [W-1:0] vd,
                        input logic [1:0] s, input logic [W-1:0] exp_v);
      @(negedge clk);
      a = va; b = vb; c = vc; d = vd;
      sel1 = s[1]; sel2 = s[0];
      exp_q.push_back(exp_v);
      name_q.push_back(nm);
   endtask

   // Monitor: every edge taken out of reset produces one output to compare.
   always @(posedge clk) begin
      if (rst_n) begin
         #1;
         if (exp_q.size() > 0) begin
            check_now(name_q.pop_front(), exp_q.pop_front());
         end
      end
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      a = 8'h01; b = 8'h01; c = 8'h01; d = 8'h01;
      sel1 = 1'b1; sel2 = 1'b1;

      #1;
      check_now("reset_async", 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_now("reset_hold", 8'h00);
      end

      // Release reset at a falling edge; the next rising edge loads d.
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(8'h01);
      name_q.push_back("reset_release");

      apply("sel_b_0",   8'h00, 8'h00, 8'h00, 8'h01, 2'b01, 8'h00);
      apply("sel_b_1",   8'h00, 8'h01, 8'h00, 8'h01, 2'b01, 8'h01);
      apply("sel_c_1",   8'h01, 8'h01, 8'h01, 8'h01, 2'b10, 8'h01);
      apply("sel_c_0",   8'h01, 8'h01, 8'h00, 8'h01, 2'b10, 8'h00);
      apply("sel_d_0",   8'h01, 8'h01, 8'h01, 8'h00, 2'b11, 8'h00);
      apply("sel_a_0",   8'h00, 8'h01, 8'h00, 8'h01, 2'b00, 8'h00);
      apply("sel_a_1",   8'h01, 8'h01, 8'h00, 8'h01, 2'b00, 8'h01);

      apply("sweep_00",  8'h11, 8'h22, 8'h33, 8'h44, 2'b00, 8'h11);
      apply("sweep_01",  8'h11, 8'h22, 8'h33, 8'h44, 2'b01, 8'h22);
      apply("sweep_10",  8'h11, 8'h22, 8'h33, 8'h44, 2'b10, 8'h33);
      apply("sweep_11",  8'h11, 8'h22, 8'h33, 8'h44, 2'b11, 8'h44);

      apply("toggle_11", 8'hA5, 8'h5A, 8'hF0, 8'h0F, 2'b11, 8'h0F);
      apply("toggle_00", 8'hA5, 8'h5A, 8'hF0, 8'h0F, 2'b00, 8'hA5);
      apply("toggle_10", 8'hA5, 8'h5A, 8'hF0, 8'h0F, 2'b10, 8'hF0);
      apply("toggle_01", 8'hA5, 8'h5A, 8'hF0, 8'h0F, 2'b01, 8'h5A);
      apply("toggle_11b",8'hC3, 8'h5A, 8'hF0, 8'h0F, 2'b11, 8'h0F);
      apply("toggle_00b",8'hC3, 8'h5A, 8'hF0, 8'h0F, 2'b00, 8'hC3);

      // Reset pulse between edges must clear y before the next clk edge.
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_now("pulse_clear", 8'h00);
      #1;
      rst_n = 1'b1;
      #1;
      check_now("pulse_stays_clear", 8'h00);

      apply("after_pulse_10", 8'hC3, 8'h3C, 8'h81, 8'h7E, 2'b10, 8'h81);
      apply("after_pulse_01", 8'hC3, 8'h3C, 8'h81, 8'h7E, 2'b01, 8'h3C);

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(negedge clk);
      end
      if (exp_q.size() > 0) begin
         n_cmp = n_cmp + 1;
         n_bad = n_bad + 1;
         $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_mux4to1_reg
